// File: rtl/imp_seq_pkg.sv
// imp_seq_pkg: shared widths and FSM state type for the pulse sequencer
package imp_seq_pkg;
  localparam int TIME_W = 64;
  localparam int FREQ_W = 48;
  localparam int INT_W  = 32;
  localparam int CNT_W  = 16;
  typedef enum logic [1:0] {IDLE, ARMED, RUN, FIN} state_t;
endpackage

// File: rtl/imp_phase_cnt.sv
// imp_phase_cnt: per-pulse phase counter with registered GATE/BLANK windows
module imp_phase_cnt
  import imp_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             run_nxt,
  input  logic             clk_en,
  input  logic [INT_W-1:0] ti,
  input  logic [INT_W-1:0] tp,
  input  logic [INT_W-1:0] tb1,
  input  logic [INT_W-1:0] tb2,
  output logic             wrap,
  output logic             gate,
  output logic             blank
);
  logic [INT_W-1:0] ph, ph_d;
  logic [INT_W:0]   blank_end;
  assign wrap      = run && clk_en && ph == tp - 1'b1;
  assign blank_end = {1'b0, ti} + {1'b0, tb2};
  // phase counts clk_en ticks while staying in RUN and parks at zero otherwise
  always_comb ph_d = (run && run_nxt) ? (clk_en ? (wrap ? '0 : ph + 1'b1) : ph) : '0;
  // windows are evaluated on the next phase so they are valid in the first RUN cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph    <= '0;
      gate  <= 1'b0;
      blank <= 1'b0;
    end else begin
      ph    <= ph_d;
      gate  <= run_nxt && ph_d < ti;
      blank <= run_nxt && (ph_d < tb1 || (ph_d >= ti && {1'b0, ph_d} < blank_end));
    end
endmodule

// File: rtl/imp_sequencer.sv
// imp_sequencer: timed pulse-train sequencer with per-pulse frequency stepping
module imp_sequencer
  import imp_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              SPI_WR,
  input  logic [TIME_W-1:0] SYS_TIME,
  input  logic [TIME_W-1:0] TIME_START,
  input  logic [CNT_W-1:0]  N_impulse,
  input  logic [7:0]        TYPE_impulse,
  input  logic [INT_W-1:0]  Interval_Ti,
  input  logic [INT_W-1:0]  Interval_Tp,
  input  logic [INT_W-1:0]  Tblank1,
  input  logic [INT_W-1:0]  Tblank2,
  input  logic [FREQ_W-1:0] FREQ,
  input  logic [FREQ_W-1:0] FREQ_STEP,
  output logic              GATE,
  output logic              BLANK,
  output logic [FREQ_W-1:0] FREQ_OUT,
  output logic              FREQ_UPD,
  output logic [CNT_W-1:0]  IMP_CNT,
  output logic              BUSY,
  output logic              DONE
);
  state_t state, state_d;
  logic [TIME_W-1:0] start_q;
  logic [CNT_W-1:0]  n_q;
  logic              type_q;
  logic [INT_W-1:0]  ti_q, tp_q, tb1_q, tb2_q;
  logic [FREQ_W-1:0] freq_q, step_q;
  logic ok, start, step, last, wrap, unused_type;
  assign unused_type = ^TYPE_impulse[7:1];
  assign ok   = N_impulse != '0 && Interval_Tp != '0;
  assign last = IMP_CNT == n_q - 1'b1;
  assign BUSY = state == ARMED || state == RUN;
  assign DONE = state == FIN;
  // a new parameter write always wins, aborting whatever is in flight
  always_comb begin
    state_d = state;
    start   = 1'b0;
    step    = 1'b0;
    if (SPI_WR) state_d = ok ? ARMED : IDLE;
    else if (state == ARMED && SYS_TIME >= start_q) begin
      state_d = RUN;
      start   = 1'b1;
    end else if (wrap) begin
      state_d = last ? FIN : RUN;
      step    = !last;
    end else if (state == FIN) state_d = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // parameter shadow copies plus pulse index and frequency word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      start_q  <= '0;
      n_q      <= '0;
      type_q   <= 1'b0;
      ti_q     <= '0;
      tp_q     <= '0;
      tb1_q    <= '0;
      tb2_q    <= '0;
      freq_q   <= '0;
      step_q   <= '0;
      IMP_CNT  <= '0;
      FREQ_OUT <= '0;
      FREQ_UPD <= 1'b0;
    end else begin
      if (SPI_WR) begin
        start_q <= TIME_START;
        n_q     <= N_impulse;
        type_q  <= TYPE_impulse[0];
        ti_q    <= Interval_Ti;
        tp_q    <= Interval_Tp;
        tb1_q   <= Tblank1;
        tb2_q   <= Tblank2;
        freq_q  <= FREQ;
        step_q  <= FREQ_STEP;
      end
      if (start) begin
        IMP_CNT  <= '0;
        FREQ_OUT <= freq_q;
      end else if (step) begin
        IMP_CNT  <= IMP_CNT + 1'b1;
        FREQ_OUT <= type_q ? FREQ_OUT + step_q : FREQ_OUT;
      end
      FREQ_UPD <= start || (step && type_q);
    end
  imp_phase_cnt u_phase (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == RUN),
    .run_nxt (state_d == RUN),
    .clk_en  (clk_en),
    .ti      (ti_q),
    .tp      (tp_q),
    .tb1     (tb1_q),
    .tb2     (tb2_q),
    .wrap    (wrap),
    .gate    (GATE),
    .blank   (BLANK)
  );
endmodule

// File: tb/tb_imp_sequencer.sv
// tb_imp_sequencer: directed and randomized checks against a tick-count reference model
module tb_imp_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, SPI_WR = 1'b0;
  logic [63:0] SYS_TIME = '0, TIME_START = '0;
  logic [15:0] N_impulse = '0;
  logic [7:0]  TYPE_impulse = '0;
  logic [31:0] Interval_Ti = '0, Interval_Tp = '0, Tblank1 = '0, Tblank2 = '0;
  logic [47:0] FREQ = '0, FREQ_STEP = '0;
  logic        GATE, BLANK, FREQ_UPD, BUSY, DONE;
  logic [47:0] FREQ_OUT;
  logic [15:0] IMP_CNT;
  logic [68:0] dut_vec;
  int vec = 0, errs = 0;
  bit auto_time = 0;

  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_FIN = 3;
  int          m_st;
  longint      k;
  logic [63:0] l_start;
  logic [15:0] l_n, m_cnt;
  logic        l_type, m_upd;
  logic [31:0] l_ti, l_tp, l_tb1, l_tb2;
  logic [47:0] l_freq, l_step, m_freq;

  always #5 clk = ~clk;

  imp_sequencer dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .SPI_WR(SPI_WR), .SYS_TIME(SYS_TIME),
    .TIME_START(TIME_START), .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse),
    .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp), .Tblank1(Tblank1), .Tblank2(Tblank2),
    .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .GATE(GATE), .BLANK(BLANK), .FREQ_OUT(FREQ_OUT),
    .FREQ_UPD(FREQ_UPD), .IMP_CNT(IMP_CNT), .BUSY(BUSY), .DONE(DONE)
  );

  assign dut_vec = {GATE, BLANK, BUSY, DONE, FREQ_UPD, IMP_CNT, FREQ_OUT};

  // Reference: RUN progress is a single tick count k; pulse = k / Tp, phase = k % Tp.
  task automatic model_reset();
    m_st = M_IDLE; k = 0; m_cnt = '0; m_freq = '0; m_upd = 1'b0;
    l_start = '0; l_n = '0; l_type = 1'b0; l_ti = '0; l_tp = '0; l_tb1 = '0; l_tb2 = '0;
    l_freq = '0; l_step = '0;
  endtask

  task automatic model_step();
    m_upd = 1'b0;
    if (SPI_WR) begin
      l_start = TIME_START; l_n = N_impulse; l_type = TYPE_impulse[0]; l_ti = Interval_Ti;
      l_tp = Interval_Tp; l_tb1 = Tblank1; l_tb2 = Tblank2; l_freq = FREQ; l_step = FREQ_STEP;
      m_st = (N_impulse == 0 || Interval_Tp == 0) ? M_IDLE : M_ARMED;
    end else if (m_st == M_ARMED) begin
      if (SYS_TIME >= l_start) begin
        m_st = M_RUN; k = 0; m_cnt = '0; m_freq = l_freq; m_upd = 1'b1;
      end
    end else if (m_st == M_RUN) begin
      if (clk_en) begin
        k++;
        if (k % longint'(l_tp) == 0) begin
          if (k / longint'(l_tp) == longint'(l_n)) m_st = M_FIN;
          else begin
            m_cnt = 16'(k / longint'(l_tp));
            if (l_type) begin
              m_freq = l_freq + l_step * 48'(m_cnt);
              m_upd = 1'b1;
            end
          end
        end
      end
    end else if (m_st == M_FIN) m_st = M_IDLE;
  endtask

  function automatic logic [68:0] exp_vec();
    longint ph;
    logic g, b;
    ph = (m_st == M_RUN) ? k % longint'(l_tp) : 0;
    g = m_st == M_RUN && ph < longint'(l_ti);
    b = m_st == M_RUN && (ph < longint'(l_tb1) ||
        (ph >= longint'(l_ti) && ph < longint'(l_ti) + longint'(l_tb2)));
    return {g, b, m_st == M_ARMED || m_st == M_RUN, m_st == M_FIN, m_upd, m_cnt, m_freq};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    if (auto_time) SYS_TIME = SYS_TIME + 1;
  endtask

  task automatic load(input logic [63:0] ts, input logic [15:0] n, input logic [7:0] ty,
                      input logic [31:0] ti, input logic [31:0] tp, input logic [31:0] b1,
                      input logic [31:0] b2, input logic [47:0] f, input logic [47:0] st);
    TIME_START = ts; N_impulse = n; TYPE_impulse = ty; Interval_Ti = ti; Interval_Tp = tp;
    Tblank1 = b1; Tblank2 = b2; FREQ = f; FREQ_STEP = st;
    SPI_WR = 1'b1;
    tick();
    SPI_WR = 1'b0;
    TIME_START = {$urandom, $urandom}; N_impulse = 16'($urandom); TYPE_impulse = 8'($urandom);
    Interval_Ti = $urandom; Interval_Tp = $urandom; Tblank1 = $urandom; Tblank2 = $urandom;
    FREQ = {16'($urandom), $urandom}; FREQ_STEP = {16'($urandom), $urandom};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset(); #2;
    vec++; if (dut_vec !== '0) begin errs++; $display("FAIL reset_state got=%h exp=0", dut_vec); end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++; if (dut_vec !== exp_vec()) begin errs++; $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_basic();
    int first = -1, done_at = -1, gates = 0, dones = 0;
    logic [63:0] t_first = '0;
    logic [47:0] fq[$];
    auto_time = 1; SYS_TIME = 90; clk_en = 1'b1;
    load(100, 3, 1, 5, 20, 2, 3, 48'h10, 48'h2);
    for (int i = 0; i < 80; i++) begin
      tick();
      vec++; if (dut_vec !== exp_vec()) begin errs++; $display("FAIL basic cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      if (GATE && first < 0) begin first = i; t_first = SYS_TIME - 1; end
      if (GATE) gates++;
      if (FREQ_UPD) fq.push_back(FREQ_OUT);
      if (DONE) begin done_at = i; dones++; end
    end
    vec++; if (t_first !== 64'd100) begin errs++; $display("FAIL basic_start got=%0d exp=100", t_first); end
    vec++; if (gates !== 15) begin errs++; $display("FAIL basic_gate_cycles got=%0d exp=15", gates); end
    vec++; if (dones !== 1 || done_at - first !== 60) begin errs++; $display("FAIL basic_done got=%0d/%0d exp=1/60", dones, done_at - first); end
    vec++; if (fq.size() !== 3) begin errs++; $display("FAIL basic_freq_count got=%0d exp=3", fq.size()); end
    else if (fq[0] !== 48'h10 || fq[1] !== 48'h12 || fq[2] !== 48'h14) begin
      errs++; $display("FAIL basic_freq got=%h,%h,%h exp=10,12,14", fq[0], fq[1], fq[2]);
    end
    auto_time = 0;
  endtask

  task automatic test_past();
    SYS_TIME = 500;
    load(0, 2, 0, 3, 6, 1, 1, 48'h55, 48'h1);
    vec++; if (BUSY !== 1'b1 || GATE !== 1'b0) begin errs++; $display("FAIL past_armed got=%b%b exp=10", BUSY, GATE); end
    tick();
    vec++; if (GATE !== 1'b1) begin errs++; $display("FAIL past_run got=%b exp=1", GATE); end
    for (int i = 0; i < 20; i++) begin
      tick();
      vec++; if (dut_vec !== exp_vec()) begin errs++; $display("FAIL past cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_wrap();
    logic [47:0] fq[$];
    load(0, 2, 1, 2, 4, 0, 0, 48'hFFFF_FFFF_FFFF, 48'h1);
    for (int i = 0; i < 15; i++) begin
      tick();
      vec++; if (dut_vec !== exp_vec()) begin errs++; $display("FAIL wrap cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      if (FREQ_UPD) fq.push_back(FREQ_OUT);
    end
    vec++; if (fq.size() !== 2) begin errs++; $display("FAIL wrap_count got=%0d exp=2", fq.size()); end
    else if (fq[0] !== 48'hFFFF_FFFF_FFFF || fq[1] !== 48'h0) begin
      errs++; $display("FAIL wrap_freq got=%h,%h exp=ffffffffffff,0", fq[0], fq[1]);
    end
  endtask

  task automatic test_abort();
    bit found = 0;
    int dones = 0;
    load(0, 4, 1, 5, 10, 1, 1, 48'h100, 48'h10);
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      vec++; if (dut_vec !== exp_vec()) begin errs++; $display("FAIL abort_run cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      found = IMP_CNT == 16'd1 && GATE;
    end
    vec++; if (!found) begin errs++; $display("FAIL abort_timeout got=no_pulse2 exp=pulse2"); end
    load(1000, 2, 0, 3, 8, 0, 0, 48'h7, 48'h0);
    vec++; if ({GATE, BLANK, BUSY, DONE} !== 4'b0010) begin errs++; $display("FAIL abort_drop got=%b exp=0010", {GATE, BLANK, BUSY, DONE}); end
    for (int i = 0; i < 40; i++) begin
      tick();
      vec++; if (dut_vec !== exp_vec()) begin errs++; $display("FAIL abort_armed cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      if (DONE) dones++;
    end
    vec++; if (dones !== 0 || BUSY !== 1'b1) begin errs++; $display("FAIL abort_nodone got=%0d/%b exp=0/1", dones, BUSY); end
    load(0, 0, 0, 3, 8, 0, 0, 48'h0, 48'h0);
    vec++; if (BUSY !== 1'b0) begin errs++; $display("FAIL abort_to_idle got=%b exp=0", BUSY); end
  endtask

  task automatic test_degenerate();
    int gates = 0, rises = 0;
    logic prev = 1'b0;
    load(0, 0, 1, 5, 20, 1, 1, 48'h9, 48'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      vec++; if (BUSY !== 1'b0 || dut_vec !== exp_vec()) begin errs++; $display("FAIL n_zero cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
    end
    load(0, 2, 0, 25, 20, 0, 0, 48'h1, 48'h0);
    for (int i = 0; i < 50; i++) begin
      tick();
      vec++; if (dut_vec !== exp_vec()) begin errs++; $display("FAIL wide_ti cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      if (GATE) gates++;
      if (GATE && !prev) rises++;
      prev = GATE;
    end
    vec++; if (gates !== 40 || rises !== 1) begin errs++; $display("FAIL wide_ti_gate got=%0d/%0d exp=40/1", gates, rises); end
  endtask

  task automatic test_quarter_reset();
    int run = 0;
    int widths[$];
    bit found = 0;
    load(0, 3, 0, 3, 5, 1, 2, 48'h1, 48'h0);
    for (int i = 0; i < 90; i++) begin
      clk_en = (i % 4 == 0);
      tick();
      vec++; if (dut_vec !== exp_vec()) begin errs++; $display("FAIL quarter cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      if (GATE) run++;
      else if (run > 0) begin widths.push_back(run); run = 0; end
    end
    vec++; if (widths.size() !== 3) begin errs++; $display("FAIL quarter_pulses got=%0d exp=3", widths.size()); end
    else if (widths[1] !== 12 || widths[2] !== 12) begin errs++; $display("FAIL quarter_width got=%0d,%0d exp=12,12", widths[1], widths[2]); end
    clk_en = 1'b1;
    load(0, 3, 1, 4, 8, 2, 2, 48'hABC, 48'h1);
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      found = GATE;
    end
    vec++; if (!found) begin errs++; $display("FAIL reset_run_timeout got=no_gate exp=gate"); end
    rst_n = 1'b0; model_reset(); #1;
    vec++; if (dut_vec !== '0) begin errs++; $display("FAIL reset_midrun got=%h exp=0", dut_vec); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vec++; if (BUSY !== 1'b0 || dut_vec !== exp_vec()) begin errs++; $display("FAIL reset_wait cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_random();
    auto_time = 1;
    for (int i = 0; i < 600; i++) begin
      clk_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0)
        load(SYS_TIME + 64'($urandom_range(0, 8)), 16'($urandom_range(0, 3)), 8'($urandom),
             $urandom_range(0, 7), $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 4),
             {16'($urandom), $urandom}, {16'($urandom), $urandom});
      else tick();
      vec++; if (dut_vec !== exp_vec()) begin errs++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
    end
    auto_time = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_past();
    test_wrap();
    test_abort();
    test_degenerate();
    test_quarter_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/imp_sequencer.md
IMP_SEQUENCER -- requirements
Module: imp_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Ports SHALL be:
- clk  in  1  system clock, 48 MHz
- rst_n  in  1  async reset, active low
- clk_en  in  1  phase-count enable
- SPI_WR  in  1  one-clk strobe: new parameter set valid (from DMA_SPI)
- SYS_TIME  in  64  current system time
- TIME_START  in  64  start time
- N_impulse  in  16  pulse count
- TYPE_impulse  in  8  bit0=1: step frequency per pulse; other bits ignored
- Interval_Ti  in  32  pulse width, clk_en ticks
- Interval_Tp  in  32  pulse period, clk_en ticks
- Tblank1  in  32  leading blank, ticks
- Tblank2  in  32  trailing blank after Ti, ticks
- FREQ  in  48  start frequency word
- FREQ_STEP  in  48  per-pulse frequency increment
- GATE  out  1  transmit pulse
- BLANK  out  1  receiver blanking
- FREQ_OUT  out  48  current frequency word
- FREQ_UPD  out  1  one-clk strobe: FREQ_OUT changed
- IMP_CNT  out  16  index of current pulse
- BUSY  out  1  state is ARMED or RUN
- DONE  out  1  one-clk strobe: sequence complete

Function
REQ-003 All parameter inputs SHALL be latched only on SPI_WR=1; the block SHALL use only the latched copies.
REQ-004 The FSM SHALL have states IDLE, ARMED, RUN, FIN.
REQ-005 IDLE: on SPI_WR, if N_impulse=0 or Interval_Tp=0, the block SHALL latch the parameters and stay in IDLE; otherwise it SHALL go to ARMED.
REQ-006 ARMED: when SYS_TIME >= latched TIME_START (unsigned 64-bit), the block SHALL go to RUN on that edge. A start time already in the past SHALL start the sequence on the next edge.
REQ-007 On entry to RUN the block SHALL set ph=0, IMP_CNT=0 and FREQ_OUT=latched FREQ, and SHALL pulse FREQ_UPD for one clk.
REQ-008 In RUN, ph SHALL advance by 1 only on clk_en=1.
REQ-009 At ph=Tp-1 with clk_en=1, the block SHALL set ph=0 and then:
- if IMP_CNT=N-1: go to FIN.
- otherwise: IMP_CNT+1; if TYPE bit0=1, FREQ_OUT += FREQ_STEP modulo 2^48 and FREQ_UPD pulses.
REQ-010 GATE SHALL be registered and equal 1 in RUN while ph < Ti. Ti=0 SHALL never gate; Ti>=Tp SHALL gate the whole period.
REQ-011 BLANK SHALL be registered and equal 1 in RUN while (ph < Tblank1) or (Ti <= ph < Ti+Tblank2). The sum SHALL be computed at 33 bits with no wrap.
REQ-012 Output timing on entry to RUN:
- GATE SHALL be 1 in the first RUN cycle when Ti>0.
- GATE and BLANK SHALL be 0 in every state except RUN.
REQ-013 FIN SHALL last one clk, assert DONE, and then go to IDLE; IMP_CNT and FREQ_OUT SHALL hold their last values.
REQ-014 SPI_WR in ARMED, RUN or FIN SHALL abort the current sequence:
- latch the new parameters and apply the REQ-005 checks.
- go to ARMED, or to IDLE if the checks fail.
- drop GATE and BLANK on the next edge.
- not assert DONE.
REQ-015 SPI_WR coincident with the final period end SHALL take priority: no DONE is produced.
REQ-016 BUSY SHALL be 1 exactly in ARMED and RUN.

Reset
REQ-017 On rst_n=0 the block SHALL, asynchronously:
- set the state to IDLE.
- clear all outputs, ph and the latched parameters to 0.
REQ-018 Reset mid-RUN SHALL drop GATE and BLANK immediately; after release the block SHALL wait for a new SPI_WR.

Structure
REQ-019 A shared package imp_seq_pkg SHALL hold:
- the FSM state enum.
- width constants: TIME_W=64, FREQ_W=48, INT_W=32, CNT_W=16.
REQ-020 The phase counter and its GATE/BLANK compare logic SHALL be one sub-module, imp_phase_cnt.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic: clk_en=1, SYS_TIME counting; SPI_WR with TIME_START=100, N=3, Ti=5, Tp=20, Tblank1=2, Tblank2=3, TYPE=1, FREQ=0x10, FREQ_STEP=0x2 -> GATE high 5 clk every 20 clk starting when SYS_TIME reaches 100; BLANK covers ph 0-1 and 5-7; FREQ_OUT = 0x10, 0x12, 0x14; DONE one clk 60 clk after start.
- Past start: TIME_START=0 while SYS_TIME=500 -> RUN one clk after SPI_WR.
- Wrap: FREQ=0xFFFF_FFFF_FFFF, FREQ_STEP=1, N=2, TYPE=1 -> second pulse FREQ_OUT=0.
- Abort: second SPI_WR mid-pulse 2 of 4 -> GATE drops next clk, no DONE, new sequence arms.
- Degenerate: N=0 -> BUSY stays 0. Ti=25, Tp=20 -> GATE continuously high for N periods.
- Reset mid-RUN and clk_en toggling at 1/4 rate -> outputs clear at once; with clk_en at 1/4, pulse width = 4*Ti clk.
